// File: rtl/cpu_pkg.sv
// Shared definitions for the multi-cycle CPU controller: instruction class codes,
// PSR flag bit positions and the controller state enumeration.
package cpu_pkg;

    localparam logic [3:0] ClsAdd   = 4'h0;
    localparam logic [3:0] ClsAddu  = 4'h1;
    localparam logic [3:0] ClsMul   = 4'h2;
    localparam logic [3:0] ClsSub   = 4'h3;
    localparam logic [3:0] ClsCmp   = 4'h4;
    localparam logic [3:0] ClsAnd   = 4'h5;
    localparam logic [3:0] ClsOr    = 4'h6;
    localparam logic [3:0] ClsXor   = 4'h7;
    localparam logic [3:0] ClsMov   = 4'h8;
    localparam logic [3:0] ClsLsh   = 4'h9;
    localparam logic [3:0] ClsLoad  = 4'hA;
    localparam logic [3:0] ClsStor  = 4'hB;
    localparam logic [3:0] ClsBcond = 4'hC;
    localparam logic [3:0] ClsJcond = 4'hD;
    localparam logic [3:0] ClsJal   = 4'hE;
    localparam logic [3:0] ClsWait  = 4'hF;

    localparam int unsigned PsrW  = 5;
    localparam int unsigned FlagC = 4;
    localparam int unsigned FlagL = 3;
    localparam int unsigned FlagF = 2;
    localparam int unsigned FlagZ = 1;
    localparam int unsigned FlagN = 0;

    typedef enum logic [2:0] {
        StFetch,
        StLatch,
        StExec,
        StMemrd,
        StHalt
    } state_e;

    // Opcodes whose ALU operand B is the register file rather than the immediate.
    function automatic logic uses_reg_operand(input logic [3:0] opcode);
        return (opcode == ClsAdd) || (opcode == ClsCmp);
    endfunction

endpackage

// File: rtl/cpu_psr.sv
// Processor status register: latches selected ALU flags per instruction class
// during EXEC; bits outside the class mask hold their value.
module cpu_psr
    import cpu_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            update_en_i,
    input  logic [3:0]      cls_i,
    input  logic [PsrW-1:0] alu_flags_i,
    output logic [PsrW-1:0] psr_o
);

    logic [PsrW-1:0] psr_d, psr_q;
    logic [PsrW-1:0] mask;

    always_comb begin
        mask = '0;
        unique case (cls_i)
            ClsAdd, ClsAddu, ClsSub: begin
                mask[FlagC] = 1'b1;
                mask[FlagF] = 1'b1;
            end
            ClsCmp: begin
                mask[FlagL] = 1'b1;
                mask[FlagZ] = 1'b1;
                mask[FlagN] = 1'b1;
            end
            default: mask = '0;
        endcase
    end

    always_comb begin
        psr_d = psr_q;
        if (update_en_i) begin
            psr_d = (psr_q & ~mask) | (alu_flags_i & mask);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            psr_q <= '0;
        end else begin
            psr_q <= psr_d;
        end
    end

    assign psr_o = psr_q;

endmodule

// File: rtl/cpu_control.sv
// Multi-cycle CPU control unit: FETCH/LATCH/EXEC(/MEMRD/HALT) sequencer, pc and ir.
// Define PIDBB_WAIT_WAKE_EN to make WAIT halt until wake; otherwise WAIT is a NOP.
module cpu_control
    import cpu_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [15:0]     mem_rdata,
    input  logic [3:0]      alu_class,
    input  logic [PsrW-1:0] alu_flags,
    input  logic [15:0]     alu_next_address,
    input  logic            wake,
    output logic [7:0]      alu_op,
    output logic [3:0]      alu_rdest_idx,
    output logic            alu_src_imm,
    output logic [15:0]     imm,
    output logic [PsrW-1:0] psr,
    output logic [15:0]     pc,
    output logic [3:0]      rf_raddr_a,
    output logic [3:0]      rf_raddr_b,
    output logic [3:0]      rf_waddr,
    output logic            rf_we,
    output logic            rf_wsel,
    output logic            mem_addr_sel,
    output logic            mem_we,
    output logic            retire
);

    state_e      state_d, state_q;
    logic [15:0] pc_d, pc_q;
    logic [15:0] ir_d, ir_q;
    logic        psr_update;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        ir_d         = ir_q;
        psr_update   = 1'b0;
        rf_we        = 1'b0;
        rf_wsel      = 1'b0;
        mem_addr_sel = 1'b0;
        mem_we       = 1'b0;
        retire       = 1'b0;

        unique case (state_q)
            StFetch: begin
                state_d = StLatch;
            end
            StLatch: begin
                ir_d    = mem_rdata;
                state_d = StExec;
            end
            StExec: begin
                psr_update = 1'b1;
                state_d    = StFetch;
                unique case (alu_class)
                    ClsCmp: begin
                        pc_d   = pc_q + 16'd1;
                        retire = 1'b1;
                    end
                    ClsLoad: begin
                        mem_addr_sel = 1'b1;
                        state_d      = StMemrd;
                    end
                    ClsStor: begin
                        mem_addr_sel = 1'b1;
                        mem_we       = 1'b1;
                        pc_d         = pc_q + 16'd1;
                        retire       = 1'b1;
                    end
                    // The ALU resolves the condition and supplies pc+1 when not taken.
                    ClsBcond, ClsJcond: begin
                        pc_d   = alu_next_address;
                        retire = 1'b1;
                    end
                    ClsJal: begin
                        rf_we  = 1'b1;
                        pc_d   = alu_next_address;
                        retire = 1'b1;
                    end
                    ClsWait: begin
`ifdef PIDBB_WAIT_WAKE_EN
                        state_d = StHalt;
`else
                        pc_d   = pc_q + 16'd1;
                        retire = 1'b1;
`endif
                    end
                    default: begin
                        rf_we  = 1'b1;
                        pc_d   = pc_q + 16'd1;
                        retire = 1'b1;
                    end
                endcase
            end
            StMemrd: begin
                rf_we   = 1'b1;
                rf_wsel = 1'b1;
                pc_d    = pc_q + 16'd1;
                retire  = 1'b1;
                state_d = StFetch;
            end
            StHalt: begin
`ifdef PIDBB_WAIT_WAKE_EN
                if (wake) begin
                    pc_d    = pc_q + 16'd1;
                    retire  = 1'b1;
                    state_d = StFetch;
                end
`else
                state_d = StFetch;
`endif
            end
            default: begin
                state_d = StFetch;
            end
        endcase
    end

`ifndef PIDBB_WAIT_WAKE_EN
    logic unused_wake;
    assign unused_wake = wake;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StFetch;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end

    cpu_psr u_psr (
        .clk_i       (clk),
        .rst_i       (reset),
        .update_en_i (psr_update),
        .cls_i       (alu_class),
        .alu_flags_i (alu_flags),
        .psr_o       (psr)
    );

    assign pc            = pc_q;
    assign alu_op        = {ir_q[15:12], ir_q[7:4]};
    assign alu_rdest_idx = ir_q[11:8];
    assign alu_src_imm   = !uses_reg_operand(ir_q[15:12]);
    assign imm           = {{8{ir_q[7]}}, ir_q[7:0]};
    assign rf_raddr_a    = ir_q[11:8];
    assign rf_raddr_b    = ir_q[3:0];
    assign rf_waddr      = ir_q[11:8];

endmodule

// File: tb/tb_cpu_control.sv
// Self-checking bench for cpu_control: directed scenarios plus random instruction mix
// against an instruction-level reference model. Honours PIDBB_WAIT_WAKE_EN.
module tb_cpu_control;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] mem_rdata;
    logic [3:0]  alu_class;
    logic [4:0]  alu_flags;
    logic [15:0] alu_next_address;
    logic        wake;
    logic [7:0]  alu_op;
    logic [3:0]  alu_rdest_idx;
    logic        alu_src_imm;
    logic [15:0] imm;
    logic [4:0]  psr;
    logic [15:0] pc;
    logic [3:0]  rf_raddr_a, rf_raddr_b, rf_waddr;
    logic        rf_we, rf_wsel, mem_addr_sel, mem_we, retire;

    int          checks = 0;
    int          failures = 0;
    logic [15:0] exp_pc;
    logic [4:0]  exp_psr;

    always #5 clk = ~clk;

    cpu_control #(.RESET_PC(16'h0000)) dut (
        .clk              (clk),
        .reset            (reset),
        .mem_rdata        (mem_rdata),
        .alu_class        (alu_class),
        .alu_flags        (alu_flags),
        .alu_next_address (alu_next_address),
        .wake             (wake),
        .alu_op           (alu_op),
        .alu_rdest_idx    (alu_rdest_idx),
        .alu_src_imm      (alu_src_imm),
        .imm              (imm),
        .psr              (psr),
        .pc               (pc),
        .rf_raddr_a       (rf_raddr_a),
        .rf_raddr_b       (rf_raddr_b),
        .rf_waddr         (rf_waddr),
        .rf_we            (rf_we),
        .rf_wsel          (rf_wsel),
        .mem_addr_sel     (mem_addr_sel),
        .mem_we           (mem_we),
        .retire           (retire)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Strobes packed as {rf_we, rf_wsel, mem_addr_sel, mem_we, retire}.
    task automatic chk_strobes(input string tag, input logic [4:0] exp);
        chk(tag, {11'd0, rf_we, rf_wsel, mem_addr_sel, mem_we, retire}, {11'd0, exp});
    endtask

    // Runs one instruction starting in FETCH; returns with the DUT in the next FETCH.
    task automatic run_instr(input logic [3:0] cls, input logic [4:0] flags,
                             input logic [15:0] nxt, input int halt_cycles);
        logic [15:0] iw;
        logic [15:0] pc0;
        logic        exp_we, exp_sel, exp_mwe, exp_ret;
        iw               = {cls, 12'($urandom)};
        pc0              = exp_pc;
        alu_class        = cls;
        alu_flags        = flags;
        alu_next_address = nxt;
        mem_rdata        = iw;
        wake             = 1'($urandom);
`ifdef PIDBB_WAIT_WAKE_EN
        wake = 1'b0;
`endif
        chk("fetch_pc", pc, pc0);
        chk_strobes("fetch_strobes", 5'b00000);
        @(negedge clk);
        chk_strobes("latch_strobes", 5'b00000);
        @(negedge clk);
        mem_rdata = 16'($urandom);
`ifdef PIDBB_WAIT_WAKE_EN
        if (cls == 4'hF && halt_cycles == 0) wake = 1'b1;
`endif
        chk("exec_alu_op", {8'd0, alu_op}, {8'd0, iw[15:12], iw[7:4]});
        chk("exec_regs", {4'd0, alu_rdest_idx, rf_raddr_a, rf_raddr_b},
            {4'd0, iw[11:8], iw[11:8], iw[3:0]});
        chk("exec_waddr", {12'd0, rf_waddr}, {12'd0, iw[11:8]});
        chk("exec_imm", imm, {{8{iw[7]}}, iw[7:0]});
        chk("exec_src_imm", {15'd0, alu_src_imm}, {15'd0, !(cls == 4'h0 || cls == 4'h4)});
        exp_we  = (cls inside {[4'h0:4'h3], [4'h5:4'h9], 4'hE});
        exp_sel = (cls inside {4'hA, 4'hB});
        exp_mwe = (cls == 4'hB);
        exp_ret = (cls != 4'hA);
`ifdef PIDBB_WAIT_WAKE_EN
        if (cls == 4'hF) exp_ret = 1'b0;
`endif
        chk_strobes("exec_strobes", {exp_we, 1'b0, exp_sel, exp_mwe, exp_ret});
        chk("exec_pc", pc, pc0);
        chk("exec_psr", {11'd0, psr}, {11'd0, exp_psr});
        if (cls inside {4'h0, 4'h1, 4'h3}) begin
            exp_psr[4] = flags[4];
            exp_psr[2] = flags[2];
        end else if (cls == 4'h4) begin
            exp_psr[3] = flags[3];
            exp_psr[1] = flags[1];
            exp_psr[0] = flags[0];
        end
        exp_pc = (cls inside {4'hC, 4'hD, 4'hE}) ? nxt : pc0 + 16'd1;
        @(negedge clk);
        if (cls == 4'hA) begin
            chk_strobes("memrd_strobes", 5'b11001);
            chk("memrd_pc", pc, pc0);
            @(negedge clk);
        end
`ifdef PIDBB_WAIT_WAKE_EN
        if (cls == 4'hF) begin
            for (int i = 0; i < halt_cycles; i++) begin
                wake = 1'b0;
                #1;
                chk_strobes("halt_strobes", 5'b00000);
                chk("halt_pc", pc, pc0);
                @(negedge clk);
            end
            wake = 1'b1;
            #1;
            chk_strobes("halt_wake_strobes", 5'b00001);
            chk("halt_wake_pc", pc, pc0);
            @(negedge clk);
            wake = 1'b0;
        end
`endif
        chk("post_pc", pc, exp_pc);
        chk("post_psr", {11'd0, psr}, {11'd0, exp_psr});
    endtask

    initial begin
        reset            = 1'b1;
        mem_rdata        = '0;
        alu_class        = '0;
        alu_flags        = '0;
        alu_next_address = '0;
        wake             = 1'b0;
        exp_pc           = 16'h0000;
        exp_psr          = 5'b00000;
        repeat (3) @(negedge clk);
        chk("rst_pc", pc, 16'h0000);
        chk("rst_psr", {11'd0, psr}, 16'd0);
        chk_strobes("rst_strobes", 5'b00000);
        chk("rst_alu_op", {8'd0, alu_op}, 16'd0);
        chk("rst_imm", imm, 16'd0);
        chk("rst_src_imm", {15'd0, alu_src_imm}, 16'd0);
        reset = 1'b0;

        run_instr(4'h0, 5'b10100, 16'h0000, 0);  // ADD: psr=10100, pc=1
        chk("add_psr", {11'd0, psr}, 16'h0014);
        run_instr(4'h4, 5'b01011, 16'h0000, 0);  // CMP: psr=11111
        chk("cmp_psr", {11'd0, psr}, 16'h001F);
        run_instr(4'h8, 5'b11111, 16'h0000, 0);
        run_instr(4'hB, 5'b00000, 16'h0000, 0);
        chk("load_start_pc", pc, 16'h0004);
        run_instr(4'hA, 5'b00000, 16'h0000, 0);  // LOAD at pc=4
        chk("load_end_pc", pc, 16'h0005);
        run_instr(4'hE, 5'b00000, 16'hFFFF, 0);  // JAL to FFFF
        run_instr(4'hD, 5'b00000, 16'h0000, 0);  // Jcond wraps to 0
        chk("jcond_wrap_pc", pc, 16'h0000);
        run_instr(4'hC, 5'b00000, 16'h0008, 0);
        run_instr(4'hD, 5'b00000, 16'h0020, 0);
        chk("jcond_pc", pc, 16'h0020);
        run_instr(4'hE, 5'b00000, 16'hFFFF, 0);
        run_instr(4'h9, 5'b00000, 16'h0000, 0);  // pc+1 wraps FFFF -> 0
        chk("inc_wrap_pc", pc, 16'h0000);
        run_instr(4'hF, 5'b00000, 16'h0000, 10); // WAIT with wake late
        run_instr(4'hF, 5'b00000, 16'h0000, 0);  // WAIT with wake early

        for (int n = 0; n < 150; n++) begin
            run_instr(4'($urandom), 5'($urandom), 16'($urandom), int'($urandom_range(0, 3)));
        end

        // Reset in the middle of a STOR EXEC cycle.
        run_instr(4'h0, 5'b10100, 16'h0000, 0);
        alu_class = 4'hB;
        mem_rdata = 16'hB123;
        @(negedge clk);
        @(negedge clk);
        chk("stor_exec_mem_we", {15'd0, mem_we}, 16'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("rst_async_mem_we", {15'd0, mem_we}, 16'd0);
        chk_strobes("rst_async_strobes", 5'b00000);
        chk("rst_async_pc", pc, 16'h0000);
        chk("rst_async_psr", {11'd0, psr}, 16'd0);
        @(negedge clk);
        @(negedge clk);
        chk("rst_hold_pc", pc, 16'h0000);
        reset   = 1'b0;
        exp_pc  = 16'h0000;
        exp_psr = 5'b00000;
        run_instr(4'h3, 5'b11111, 16'h0000, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cpu_control.md
CPU_CONTROL -- requirements
Module: cpu_control

Interface
REQ-001 Parameter RESET_PC, 16'h0000, value loaded into pc on reset.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 reset  in  1  asynchronous, active-high; forces the Reset state immediately, independent of clk.
REQ-004 mem_rdata  in  16  unified memory read data, valid one cycle after mem_addr is presented.
REQ-005 alu_class  in  4  ALU encoded class: ADD 0000, ADDU 0001, MUL 0010, SUB 0011, CMP 0100, AND/OR/XOR 0101-0111, MOV 1000, LSH 1001, LOAD 1010, STOR 1011, Bcond 1100, Jcond 1101, JAL 1110, WAIT 1111.
REQ-006 alu_flags  in  5  ALU combinational flags {C,L,F,Z,N}; alu_next_address  in  16  ALU target address.
REQ-007 wake  in  1  level wake request for WAIT.
REQ-008 alu_op  out  8  {ir[15:12], ir[7:4]}; alu_rdest_idx  out  4  ir[11:8]; alu_src_imm  out  1  immediate select; imm  out  16  sign-extended ir[7:0].
REQ-009 psr  out  5  latched flags {C,L,F,Z,N}, driven to ALU flag input; pc  out  16  current address.
REQ-010 rf_raddr_a / rf_raddr_b / rf_waddr  out  4 each  ir[11:8] / ir[3:0] / ir[11:8]; rf_we  out  1; rf_wsel  out  1  (0 ALU result, 1 mem_rdata).
REQ-011 mem_addr_sel  out  1  (0 pc, 1 rf port B data); mem_we  out  1  store strobe; retire  out  1  one-cycle pulse per completed instruction.

Function
REQ-012 States: FETCH, LATCH, EXEC, MEMRD, HALT; one-hot not required.
REQ-013 FETCH: mem_addr_sel=0; next LATCH.
REQ-014 LATCH: ir <= mem_rdata; next EXEC. Instruction latency minimum 3 cycles, loads 4.
REQ-015 alu_src_imm = 1 unless ir[15:12] is 0000 or 0100.
REQ-016 EXEC, classes 0000-1001 except CMP: rf_we=1, rf_wsel=0, pc <= pc+1, retire, next FETCH.
REQ-017 EXEC, CMP: rf_we=0; pc <= pc+1; retire.
REQ-018 psr update in EXEC only: ADD/ADDU/SUB write C,F from alu_flags; CMP writes L,Z,N; all other classes and bits hold.
REQ-019 EXEC, LOAD: mem_addr_sel=1, rf_we=0; next MEMRD. MEMRD: rf_we=1, rf_wsel=1, pc <= pc+1, retire, next FETCH.
REQ-020 EXEC, STOR: mem_addr_sel=1, mem_we=1 for exactly one cycle; pc <= pc+1; retire.
REQ-021 EXEC, Bcond/Jcond: pc <= alu_next_address (ALU supplies pc+1 when not taken); rf_we=0; retire.
REQ-022 EXEC, JAL: rf_we=1, rf_wsel=0 (return address), pc <= alu_next_address; retire.
REQ-023 pc arithmetic modulo 2^16; 16'hFFFF+1 wraps to 16'h0000.
REQ-024 rf_we, mem_we, retire are 0 in every state/class not listed above.

Reset
REQ-025 On reset: state=FETCH, pc=RESET_PC, ir=0, psr=0, rf_we=0, mem_we=0, retire=0; all other outputs decode from ir=0.
REQ-026 Reset asserted mid-instruction (any state incl. MEMRD, HALT) aborts it: no register or memory write occurs in that cycle.
REQ-027 First FETCH occurs in the first rising clk edge after reset deasserts.

Configuration
REQ-028 Macro PIDBB_WAIT_WAKE_EN defined: EXEC with WAIT enters HALT without retiring; HALT holds pc and all strobes 0 until wake=1, then pc <= pc+1, retire, next FETCH; wake already high in EXEC leaves HALT the following cycle.
REQ-029 Macro undefined: WAIT behaves as NOP (pc <= pc+1, retire, next FETCH); HALT unreachable and wake ignored.

Structure
REQ-030 Shared package cpu_pkg holds the 4-bit class constants, the flag bit indices (C=4, L=3, F=2, Z=1, N=0) and the state enumeration; the ALU moves to the same constants.
REQ-031 One sub-module, cpu_psr, holds the 5-bit flag register and its per-class bit masks; next-state logic and pc stay in cpu_control.

Verification
REQ-032 Reset then ADD with alu_flags=5'b10100 -> rf_we high exactly in EXEC (cycle 3), psr=5'b10100, pc=1, retire one pulse.
REQ-033 CMP with alu_flags=5'b01011 after psr=5'b10100 -> psr=5'b11111, rf_we never high, pc+1.
REQ-034 LOAD at pc=4 with mem_rdata=16'hBEEF in MEMRD -> mem_addr_sel=1 in EXEC, rf_we and rf_wsel=1 in MEMRD only, pc=5, 4 cycles total.
REQ-035 Jcond at pc=16'hFFFF with alu_next_address=16'h0000 -> pc=0; same at pc=8 with alu_next_address=16'h0020 -> pc=16'h0020.
REQ-036 With PIDBB_WAIT_WAKE_EN: WAIT, wake low 10 cycles then high -> pc frozen 10 cycles, then pc+1 and one retire; without macro -> pc+1 after 3 cycles.
REQ-037 Reset asserted during STOR EXEC -> mem_we drops immediately asynchronously, pc=RESET_PC, psr=0.
